// File: rtl/rat_add_seq.sv
// Multi-cycle rational adder s = l + r sharing one WIDTH x WIDTH multiplier.
// Optional overflow flag output enabled by defining RAT_ADD_SEQ_OVF_EN.
module rat_add_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] l_num,
    input  logic [WIDTH-1:0] l_den,
    input  logic [WIDTH-1:0] r_num,
    input  logic [WIDTH-1:0] r_den,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s_num,
    output logic [WIDTH-1:0] s_den,
    output logic             div0,
    output logic             busy
`ifdef RAT_ADD_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MUL_A = 3'd1;
    localparam logic [2:0] S_MUL_B = 3'd2;
    localparam logic [2:0] S_MUL_C = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       r_state;
    logic [WIDTH-1:0] r_l_num, r_l_den, r_r_num, r_r_den;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_s_num, r_s_den;
    logic             r_div0;

    logic [WIDTH-1:0] w_mul_a, w_mul_b;
    logic [WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_sum_b;
    logic [WIDTH-1:0] w_sum_fast;

    // Operand selection for the single shared multiplier, one product per state.
    always_comb begin
        w_mul_a = r_l_den;
        w_mul_b = r_r_den;
        case (r_state)
            S_MUL_A: begin
                w_mul_a = r_l_num;
                w_mul_b = r_r_den;
            end
            S_MUL_B: begin
                w_mul_a = r_r_num;
                w_mul_b = r_l_den;
            end
            default: begin
                w_mul_a = r_l_den;
                w_mul_b = r_r_den;
            end
        endcase
    end

`ifdef RAT_ADD_SEQ_OVF_EN
    logic [2*WIDTH-1:0] w_prod_full;
    logic               w_prod_hi;
    logic               w_carry_b;
    logic               w_carry_fast;
    logic               r_ovf;

    assign w_prod_full = {{WIDTH{1'b0}}, w_mul_a} * {{WIDTH{1'b0}}, w_mul_b};
    assign w_prod      = w_prod_full[WIDTH-1:0];
    assign w_prod_hi   = |w_prod_full[2*WIDTH-1:WIDTH];
    assign {w_carry_b, w_sum_b}       = {1'b0, r_acc} + {1'b0, w_prod};
    assign {w_carry_fast, w_sum_fast} = {1'b0, l_num} + {1'b0, r_num};
    assign ovf = r_ovf & ~r_div0;
`else
    assign w_prod     = w_mul_a * w_mul_b;
    assign w_sum_b    = r_acc + w_prod;
    assign w_sum_fast = l_num + r_num;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_l_num <= '0;
            r_l_den <= '0;
            r_r_num <= '0;
            r_r_den <= '0;
            r_acc   <= '0;
            r_s_num <= '0;
            r_s_den <= '0;
            r_div0  <= 1'b0;
`ifdef RAT_ADD_SEQ_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_l_num <= l_num;
                        r_l_den <= l_den;
                        r_r_num <= r_num;
                        r_r_den <= r_den;
`ifdef RAT_ADD_SEQ_OVF_EN
                        r_ovf   <= 1'b0;
`endif
                        if (l_den == '0 || r_den == '0) begin
                            r_s_num <= '0;
                            r_s_den <= '0;
                            r_div0  <= 1'b1;
                            r_state <= S_DONE;
                        end else if (l_den == r_den) begin
                            r_s_num <= w_sum_fast;
                            r_s_den <= l_den;
                            r_div0  <= 1'b0;
`ifdef RAT_ADD_SEQ_OVF_EN
                            r_ovf   <= w_carry_fast;
`endif
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_MUL_A;
                        end
                    end
                end
                S_MUL_A: begin
                    r_acc   <= w_prod;
`ifdef RAT_ADD_SEQ_OVF_EN
                    r_ovf   <= r_ovf | w_prod_hi;
`endif
                    r_state <= S_MUL_B;
                end
                S_MUL_B: begin
                    r_s_num <= w_sum_b;
`ifdef RAT_ADD_SEQ_OVF_EN
                    r_ovf   <= r_ovf | w_prod_hi | w_carry_b;
`endif
                    r_state <= S_MUL_C;
                end
                S_MUL_C: begin
                    r_s_den <= w_prod;
                    r_div0  <= 1'b0;
`ifdef RAT_ADD_SEQ_OVF_EN
                    r_ovf   <= r_ovf | w_prod_hi;
`endif
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign s_num     = r_s_num;
    assign s_den     = r_s_den;
    assign div0      = r_div0;

endmodule

// File: tb/tb_rat_add_seq.sv
// Bench for rat_add_seq (WIDTH=8): directed literal cases plus randomized
// traffic checked every cycle against a plain-arithmetic reference model.
module tb_rat_add_seq;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] l_num, l_den, r_num, r_den;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s_num, s_den;
    logic         div0;
    logic         busy;
`ifdef RAT_ADD_SEQ_OVF_EN
    logic         ovf;
`endif

    int n_err = 0;
    int n_chk = 0;
    logic chk_en = 1'b0;

    rat_add_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .l_num     (l_num),
        .l_den     (l_den),
        .r_num     (r_num),
        .r_den     (r_den),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s_num     (s_num),
        .s_den     (s_den),
        .div0      (div0),
        .busy      (busy)
`ifdef RAT_ADD_SEQ_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: accept -> compute the result from rational arithmetic,
    // then a latency countdown (1 edge fast/div0, 4 edges slow) and a handshake.
    logic        m_busy = 1'b0, m_valid = 1'b0;
    int          m_wait = 0;
    int unsigned m_num = 0, m_den = 0;
    logic        m_div0 = 1'b0, m_ovf = 1'b0;

    always @(posedge clk) begin
        int unsigned a, b, c, d, p1, p2, p3, s;
        if (rst) begin
            m_busy = 0; m_valid = 0; m_wait = 0;
            m_num = 0; m_den = 0; m_div0 = 0; m_ovf = 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                a = int'(l_num); b = int'(l_den); c = int'(r_num); d = int'(r_den);
                m_busy = 1;
                if (b == 0 || d == 0) begin
                    m_num = 0; m_den = 0; m_div0 = 1; m_ovf = 0; m_valid = 1;
                end else if (b == d) begin
                    s = a + c;
                    m_num = s % 256; m_den = b; m_div0 = 0; m_ovf = (s > 255); m_valid = 1;
                end else begin
                    p1 = a * d; p2 = c * b; p3 = b * d;
                    m_num = (p1 + p2) % 256;
                    m_den = p3 % 256;
                    m_div0 = 0;
                    m_ovf = (p1 > 255) || (p2 > 255) || (p3 > 255) || ((p1 % 256 + p2 % 256) > 255);
                    m_valid = 0; m_wait = 3;
                end
            end
        end else if (!m_valid) begin
            m_wait--;
            if (m_wait == 0) m_valid = 1;
        end else if (out_ready) begin
            m_busy = 0; m_valid = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 32'(in_ready), 32'(!m_busy));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                chk("s_num", 32'(s_num), m_num);
                chk("s_den", 32'(s_den), m_den);
                chk("div0", 32'(div0), 32'(m_div0));
`ifdef RAT_ADD_SEQ_OVF_EN
                chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
            end
        end
    end

    task automatic do_op(input string tag, input logic [7:0] ln, ld, rn, rd,
                         input int exp_lat, input logic [7:0] en, ed,
                         input logic ediv0, eovf, input int hold);
        int lat;
        @(negedge clk);
        l_num = ln; l_den = ld; r_num = rn; r_den = rd;
        in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_s_num"}, 32'(s_num), 32'(en));
        chk({tag, "_s_den"}, 32'(s_den), 32'(ed));
        chk({tag, "_div0"}, 32'(div0), 32'(ediv0));
`ifdef RAT_ADD_SEQ_OVF_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'(eovf));
`else
        if (eovf === 1'bx) $display("unreachable");
`endif
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            in_valid = k[0];
            l_num = 8'($urandom); l_den = 8'($urandom);
            r_num = 8'($urandom); r_den = 8'($urandom);
        end
        if (hold > 0) begin
            chk({tag, "_held_num"}, 32'(s_num), 32'(en));
            chk({tag, "_held_den"}, 32'(s_den), 32'(ed));
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        l_num = '0; l_den = '0; r_num = '0; r_den = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_s_num", 32'(s_num), 32'd0);
        chk("rst_s_den", 32'(s_den), 32'd0);
        chk("rst_div0", 32'(div0), 32'd0);
        chk_en = 1'b1;
        rst = 1'b0;

        do_op("fast", 8'd3, 8'd7, 8'd2, 8'd7, 1, 8'd5, 8'd7, 1'b0, 1'b0, 0);
        do_op("slow", 8'd1, 8'd2, 8'd1, 8'd3, 4, 8'd5, 8'd6, 1'b0, 1'b0, 0);
        do_op("bp", 8'd2, 8'd3, 8'd1, 8'd4, 4, 8'd11, 8'd12, 1'b0, 1'b0, 10);
        do_op("zden", 8'd5, 8'd0, 8'd1, 8'd3, 1, 8'd0, 8'd0, 1'b1, 1'b0, 0);
        do_op("one", 8'd1, 8'd1, 8'd1, 8'd1, 1, 8'd2, 8'd1, 1'b0, 1'b0, 0);
        do_op("wrap", 8'd200, 8'd3, 8'd100, 8'd5, 4, 8'd20, 8'd15, 1'b0, 1'b1, 0);

        // Reset asserted while the op sits in MUL_B.
        @(negedge clk);
        l_num = 8'd1; l_den = 8'd2; r_num = 8'd1; r_den = 8'd3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_s_num", 32'(s_num), 32'd0);
        chk("midrst_s_den", 32'(s_den), 32'd0);
        repeat (6) @(negedge clk);
        chk("midrst_no_result", 32'(out_valid), 32'd0);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst       = (($urandom % 200) == 0);
            in_valid  = (($urandom % 2) == 0);
            out_ready = (($urandom % 4) != 0);
            l_num = 8'($urandom);
            r_num = 8'($urandom);
            l_den = (($urandom % 10) == 0) ? 8'd0 : 8'($urandom);
            case ($urandom % 8)
                0:       r_den = 8'd0;
                1, 2, 3: r_den = l_den;
                default: r_den = 8'($urandom);
            endcase
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("final_idle", 32'(in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
